// File: rtl/bus_router.sv
// bus_router: decodes master address phases onto NSLAVE base/mask windows and routes the data phase back.
// Optional hung-slave timeout is compiled in when BUS_ROUTER_TIMEOUT_EN is defined.
module bus_router #(
    parameter int                     NSLAVE    = 6,
    parameter int                     DATA_W    = 32,
    parameter logic [NSLAVE*32-1:0]   SLV_BASE  = {NSLAVE{32'h0}},
    parameter logic [NSLAVE*32-1:0]   SLV_MASK  = {NSLAVE{32'h0}},
    parameter int                     TIMEOUT_W = 8
) (
    input  logic                     Hclock,
    input  logic                     Hreset,
    input  logic                     Hvalid,
    input  logic                     Hwrite,
    input  logic                     Hsize,
    input  logic [31:0]              Haddress,
    input  logic [DATA_W-1:0]        Hwritedata,
    output logic [DATA_W-1:0]        Hreaddata,
    output logic                     Hready,
    output logic                     Hresponse,
    output logic [NSLAVE-1:0]        s_select,
    output logic                     s_write,
    output logic                     s_size,
    output logic [31:0]              s_address,
    output logic [DATA_W-1:0]        s_writedata,
    output logic [NSLAVE-1:0]        s_abort,
    input  logic [NSLAVE*DATA_W-1:0] s_readdata,
    input  logic [NSLAVE-1:0]        s_ready,
    input  logic [NSLAVE-1:0]        s_response
);

    localparam int IDX_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   cur_q;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               accept;
    logic               cur_ready;
    logic               cur_resp;
    logic [DATA_W-1:0]  cur_rdata;
    logic               tmo_hit;

    // Scan from the top down so the lowest-index matching window is the one left standing.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((Haddress & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign cur_ready = s_ready[cur_q];
    assign cur_resp  = s_response[cur_q];
    assign cur_rdata = s_readdata[cur_q*DATA_W +: DATA_W];

    always_comb begin
        Hready    = 1'b1;
        Hresponse = 1'b0;
        Hreaddata = '0;
        case (state_q)
            DATA: begin
                Hready    = cur_ready | tmo_hit;
                Hresponse = (cur_resp & cur_ready) | tmo_hit;
                Hreaddata = cur_rdata;
            end
            ERR:     Hresponse = 1'b1;
            default: ;
        endcase
    end

    assign accept = Hvalid && Hready;

    // Completion with a simultaneous accept chains straight into the next data phase.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Hclock) begin
        if (Hreset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            s_select    <= '0;
            s_write     <= 1'b0;
            s_size      <= 1'b0;
            s_address   <= '0;
            s_writedata <= '0;
        end else begin
            s_select <= '0;
            if (accept) begin
                s_write     <= Hwrite;
                s_size      <= Hsize;
                s_address   <= Haddress;
                s_writedata <= Hwritedata;
                if (hit) begin
                    state_q           <= DATA;
                    cur_q             <= hit_idx;
                    s_select[hit_idx] <= 1'b1;
                end else begin
                    state_q <= ERR;
                end
            end else if (Hready) begin
                state_q <= IDLE;
            end
        end
    end

`ifdef BUS_ROUTER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q;

    // Counts wait cycles of the current data phase; saturation is the abort trigger.
    always_ff @(posedge Hclock) begin
        if (Hreset || accept) begin
            tmo_q <= '0;
        end else if (state_q == DATA && !cur_ready && !(&tmo_q)) begin
            tmo_q <= tmo_q + TIMEOUT_W'(1);
        end
    end

    assign tmo_hit = (state_q == DATA) && !cur_ready && (&tmo_q);
    assign s_abort = tmo_hit ? (NSLAVE'(1) << cur_q) : '0;
`else
    localparam int unused_timeout_w = TIMEOUT_W;

    assign tmo_hit = 1'b0;
    assign s_abort = '0;
`endif

endmodule

// File: tb/tb_bus_router.sv
// Scoreboard bench for bus_router: predictions queued at accept, compared when the data phase completes.
module tb_bus_router;

    localparam int NS       = 2;
    localparam int DW       = 32;
    localparam int TW       = 4;
    localparam int HANG_LAT = (1 << TW);

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic            hvalid = 1'b0;
    logic            hwrite = 1'b0;
    logic            hsize  = 1'b0;
    logic [31:0]     haddr  = '0;
    logic [DW-1:0]   hwdata = '0;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic            hresp;
    logic [NS-1:0]   s_select;
    logic            s_write;
    logic            s_size;
    logic [31:0]     s_address;
    logic [DW-1:0]   s_writedata;
    logic [NS-1:0]   s_abort;
    logic [NS*DW-1:0] s_readdata;
    logic [NS-1:0]   s_ready = '0;
    logic [NS-1:0]   s_response;

    logic [DW-1:0]   o_hrdata;
    logic            o_hready;
    logic            o_hresp;
    logic [NS-1:0]   o_s_select;
    logic            o_s_write;
    logic            o_s_size;
    logic [31:0]     o_s_address;
    logic [DW-1:0]   o_s_writedata;
    logic [NS-1:0]   o_s_abort;

    logic [31:0]     win_base [NS] = '{32'h0000_0000, 32'h1FD0_03F8};
    logic [31:0]     win_mask [NS] = '{32'hFFC0_0000, 32'hFFFF_FFF8};

    int              wait_cfg  [NS] = '{0, 0};
    logic [DW-1:0]   rdata_cfg [NS] = '{32'hDEAD_BEEF, 32'h0000_0055};
    logic            resp_cfg  [NS] = '{1'b0, 1'b0};
    int              cnt       [NS] = '{0, 0};
    bit              busy      [NS] = '{1'b0, 1'b0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign s_readdata = {rdata_cfg[1], rdata_cfg[0]};
    assign s_response = {resp_cfg[1], resp_cfg[0]};

    bus_router #(
        .NSLAVE   (NS),
        .DATA_W   (DW),
        .SLV_BASE ({32'h1FD0_03F8, 32'h0000_0000}),
        .SLV_MASK ({32'hFFFF_FFF8, 32'hFFC0_0000}),
        .TIMEOUT_W(TW)
    ) u_dut (
        .Hclock     (clk),
        .Hreset     (rst),
        .Hvalid     (hvalid),
        .Hwrite     (hwrite),
        .Hsize      (hsize),
        .Haddress   (haddr),
        .Hwritedata (hwdata),
        .Hreaddata  (hrdata),
        .Hready     (hready),
        .Hresponse  (hresp),
        .s_select   (s_select),
        .s_write    (s_write),
        .s_size     (s_size),
        .s_address  (s_address),
        .s_writedata(s_writedata),
        .s_abort    (s_abort),
        .s_readdata (s_readdata),
        .s_ready    (s_ready),
        .s_response (s_response)
    );

    // Overlapping windows: every address below 0x01000000 hits both slaves.
    bus_router #(
        .NSLAVE   (NS),
        .DATA_W   (DW),
        .SLV_BASE ({32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK ({32'hFF00_0000, 32'hF000_0000}),
        .TIMEOUT_W(TW)
    ) u_ovl (
        .Hclock     (clk),
        .Hreset     (rst),
        .Hvalid     (hvalid),
        .Hwrite     (hwrite),
        .Hsize      (hsize),
        .Haddress   (haddr),
        .Hwritedata (hwdata),
        .Hreaddata  (o_hrdata),
        .Hready     (o_hready),
        .Hresponse  (o_hresp),
        .s_select   (o_s_select),
        .s_write    (o_s_write),
        .s_size     (o_s_size),
        .s_address  (o_s_address),
        .s_writedata(o_s_writedata),
        .s_abort    (o_s_abort),
        .s_readdata ({32'hB1B1_B1B1, 32'hA0A0_A0A0}),
        .s_ready    (2'b11),
        .s_response (2'b00)
    );

    typedef struct {
        logic [NS-1:0] sel;
        logic [NS-1:0] abort;
        logic          resp;
        logic [DW-1:0] rdata;
        bit            chk_data;
        int            lat;
        logic          wr;
        logic          sz;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    bit   pending = 1'b0;
    bit   first   = 1'b0;
    int   cyc     = 0;
    int   acc_log[$];
    int   done_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t predict(input logic wr, input logic sz, input logic [31:0] a,
                                     input logic [DW-1:0] d, input int c);
        exp_t e;
        int   idx = -1;
        for (int i = 0; i < NS; i++)
            if (idx < 0 && (a & win_mask[i]) == win_base[i]) idx = i;
        e.wr = wr; e.sz = sz; e.addr = a; e.wdata = d; e.acc_cyc = c;
        e.abort = '0; e.rdata = '0; e.chk_data = 1'b1; e.sel = '0;
        if (idx < 0) begin
            e.resp = 1'b1;
            e.lat  = 1;
        end else begin
            e.sel = NS'(1) << idx;
            if (wait_cfg[idx] < 0) begin
`ifdef BUS_ROUTER_TIMEOUT_EN
                e.resp = 1'b1; e.chk_data = 1'b0; e.lat = HANG_LAT; e.abort = e.sel;
`else
                e.resp = 1'b0; e.chk_data = 1'b0; e.lat = -1;
`endif
            end else begin
                e.resp  = resp_cfg[idx];
                e.rdata = rdata_cfg[idx];
                e.lat   = 1 + wait_cfg[idx];
            end
        end
        return e;
    endfunction

    // Slave model: after s_select, hold s_ready low for wait_cfg cycles (negative = never ready).
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (rst) begin
                busy[i]    = 1'b0;
                s_ready[i] = 1'b0;
            end else if (s_select[i]) begin
                busy[i]    = 1'b1;
                cnt[i]     = wait_cfg[i];
                s_ready[i] = (cnt[i] == 0);
            end else if (busy[i]) begin
                if (s_ready[i]) begin
                    busy[i]    = 1'b0;
                    s_ready[i] = 1'b0;
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                    s_ready[i] = (cnt[i] == 0);
                end
            end
        end
    end

    // Monitor: retire the head prediction on completion, then queue a new one on accept.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            pending = 1'b0;
            sb.delete();
        end else begin
            if (pending) begin
                e = sb[0];
                if (first) begin
                    check("sel", s_select, e.sel);
                    check("addr", s_address, e.addr);
                    check("size", s_size, e.sz);
                    first = 1'b0;
                end else begin
                    check("sel_pulse", s_select, '0);
                end
                check("s_write", s_write, e.wr);
                check("s_wdata", s_writedata, e.wdata);
                if (hready) begin
                    check("lat", cyc - e.acc_cyc, e.lat);
                    check("resp", hresp, e.resp);
                    if (e.chk_data) check("rdata", hrdata, e.rdata);
                    check("abort", s_abort, e.abort);
                    void'(sb.pop_front());
                    done_log.push_back(cyc);
                    pending = 1'b0;
                end else begin
                    check("resp_wait", hresp, 1'b0);
                    check("abort_wait", s_abort, '0);
                end
            end else begin
                check("idle_rdy", hready, 1'b1);
                check("idle_resp", hresp, 1'b0);
                check("idle_rdata", hrdata, '0);
                check("idle_abort", s_abort, '0);
            end
            if (hvalid && hready) begin
                sb.push_back(predict(hwrite, hsize, haddr, hwdata, cyc));
                acc_log.push_back(cyc);
                pending = 1'b1;
                first   = 1'b1;
            end
        end
    end

    task automatic xfer(input logic wr, input logic sz, input logic [31:0] a, input logic [DW-1:0] d);
        int n = 0;
        hvalid = 1'b1; hwrite = wr; hsize = sz; haddr = a; hwdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!hready && n < 100);
        check("accept_wait", hready, 1'b1);
        @(posedge clk); #2;
        hvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((pending || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk); #2;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rdy", hready, 1'b1);
        check("rst_mid_resp", hresp, 1'b0);
        check("rst_mid_sel", s_select, '0);
        check("rst_mid_addr", s_address, '0);
        @(posedge clk); #2;
    endtask

    initial begin
        logic [31:0] addr_tab [8] = '{32'h0000_0010, 32'h003F_FFFC, 32'h1FD0_03F8, 32'h1FD0_03FF,
                                      32'h0040_0000, 32'h1FD0_0400, 32'hFFFF_FFFF, 32'h0000_0000};

        @(posedge clk); #2;
        @(negedge clk);
        check("rst_sel", s_select, '0);
        check("rst_abort", s_abort, '0);
        check("rst_write", s_write, 1'b0);
        check("rst_size", s_size, 1'b0);
        check("rst_addr", s_address, '0);
        check("rst_wdata", s_writedata, '0);
        check("rst_rdy", hready, 1'b1);
        check("rst_resp", hresp, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Zero-wait read, waited write, unmapped access, slave error response.
        xfer(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
        drain();
        wait_cfg[1] = 3;
        xfer(1'b1, 1'b0, 32'h1FD0_03F8, 32'h0000_0041);
        drain();
        xfer(1'b0, 1'b1, 32'h2000_0000, 32'h0);
        drain();
        wait_cfg[1] = 1; resp_cfg[1] = 1'b1;
        xfer(1'b0, 1'b1, 32'h1FD0_03FC, 32'h0);
        drain();
        resp_cfg[1] = 1'b0;

        // Overlapping windows in the second instance: only the lowest index is selected.
        wait_cfg[0] = 0;
        xfer(1'b0, 1'b1, 32'h0000_0100, 32'h0);
        @(negedge clk);
        check("ovl_sel", o_s_select, 2'b01);
        check("ovl_rdy", o_hready, 1'b1);
        check("ovl_rdata", o_hrdata, 32'hA0A0_A0A0);
        drain();

        // Back-to-back: each next request is accepted in the completion cycle of the previous one.
        wait_cfg[1] = 2;
        acc_log.delete(); done_log.delete();
        xfer(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        xfer(1'b1, 1'b1, 32'h1FD0_03F8, 32'h0000_0077);
        xfer(1'b0, 1'b0, 32'h2000_0000, 32'h0);
        drain();
        check("b2b_gap1", acc_log[1], done_log[0]);
        check("b2b_gap2", acc_log[2], done_log[1]);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NS; i++) begin
                wait_cfg[i]  = $urandom_range(0, 3);
                resp_cfg[i]  = 1'($urandom_range(0, 1));
                rdata_cfg[i] = $urandom;
            end
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr_tab[k], $urandom);
            drain();
        end
        resp_cfg[0] = 1'b0; resp_cfg[1] = 1'b0;

        // Hung slave: timeout build terminates it, default build waits until reset.
        wait_cfg[1] = -1;
        xfer(1'b0, 1'b1, 32'h1FD0_03F8, 32'h0);
`ifdef BUS_ROUTER_TIMEOUT_EN
        drain();
        xfer(1'b0, 1'b1, 32'h1FD0_03F8, 32'h0);
        repeat (5) @(negedge clk);
        check("hang_held", sb.size(), 1);
`else
        repeat (40) @(negedge clk);
        check("hang_held", sb.size(), 1);
`endif
        pulse_reset();

        wait_cfg[1] = 0;
        xfer(1'b0, 1'b1, 32'h1FD0_03F8, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
